// File: rtl/div_share_arbiter_if.sv
// div_share_arbiter_if
// Groups the requester-facing and divider-facing signals of div_share_arbiter.
//   req_in, dividend*_in, divisor*_in    : two requesters (level requests + operands)
//   ack_out, result_valid_out            : per-requester grant / result pulses
//   quotient_out, err_out, busy_out      : shared result bus and status
//   div_start_out, div_dividend_out,
//   div_divisor_out, div_quotient_in,
//   div_busy_in                          : shared unsigned divider handshake
// Modports: slave = arbiter side, master = requesters + divider side.
interface div_share_arbiter_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DWIDTH = 16
);
    logic [1:0]              req_in;
    logic signed [WIDTH-1:0] dividend0_in;
    logic signed [WIDTH-1:0] dividend1_in;
    logic [DWIDTH-1:0]       divisor0_in;
    logic [DWIDTH-1:0]       divisor1_in;
    logic [1:0]              ack_out;
    logic [1:0]              result_valid_out;
    logic signed [WIDTH-1:0] quotient_out;
    logic                    err_out;
    logic                    busy_out;
    logic                    div_start_out;
    logic [WIDTH-1:0]        div_dividend_out;
    logic [WIDTH-1:0]        div_divisor_out;
    logic [WIDTH-1:0]        div_quotient_in;
    logic                    div_busy_in;

    modport slave (
        input  req_in, dividend0_in, dividend1_in, divisor0_in, divisor1_in,
        input  div_quotient_in, div_busy_in,
        output ack_out, result_valid_out, quotient_out, err_out, busy_out,
        output div_start_out, div_dividend_out, div_divisor_out
    );

    modport master (
        output req_in, dividend0_in, dividend1_in, divisor0_in, divisor1_in,
        output div_quotient_in, div_busy_in,
        input  ack_out, result_valid_out, quotient_out, err_out, busy_out,
        input  div_start_out, div_dividend_out, div_divisor_out
    );
endinterface

// File: rtl/div_share_arbiter.sv
// div_share_arbiter
// Shares one unsigned divider between two requesters doing signed division.
// Round-robin arbitration, one operation in flight, sign handled around the divider,
// divide-by-zero short-circuit and a WAIT timeout.
// Ports:
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : div_share_arbiter_if.slave (requesters + divider handshake)
module div_share_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk_in,
    input logic              rst_n_in,
    div_share_arbiter_if.slave bus
);
    // Counter only needs to reach TIMEOUT-1: the edge that sees that value with busy
    // still high is the TIMEOUT-th WAIT cycle.
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StLaunch, StGuard, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic              winner_q, winner_d;
    logic              prio_q, prio_d;     // requester that wins a tie
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [DWIDTH-1:0] divisor_q, divisor_d;
    logic              neg_q, neg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic              err_q, err_d;

    logic              pick;
    logic [WIDTH-1:0]  dvd_sel;
    logic [1:0]        winner_onehot;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= StIdle;
            winner_q  <= 1'b0;
            prio_q    <= 1'b0;
            mag_q     <= '0;
            divisor_q <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            quot_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            prio_q    <= prio_d;
            mag_q     <= mag_d;
            divisor_q <= divisor_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        prio_d    = prio_q;
        mag_d     = mag_q;
        divisor_d = divisor_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        err_d     = err_q;

        // A lone request wins outright; the pointer only breaks ties.
        pick = prio_q;
        if (bus.req_in == 2'b01) begin
            pick = 1'b0;
        end else if (bus.req_in == 2'b10) begin
            pick = 1'b1;
        end
        dvd_sel = pick ? bus.dividend1_in : bus.dividend0_in;

        unique case (state_q)
            StIdle: begin
                if (bus.req_in != 2'b00) begin
                    winner_d  = pick;
                    prio_d    = ~pick;
                    neg_d     = dvd_sel[WIDTH-1];
                    // Most negative value negates to itself, which is the correct
                    // unsigned magnitude 2^(WIDTH-1).
                    mag_d     = dvd_sel[WIDTH-1] ? ('0 - dvd_sel) : dvd_sel;
                    divisor_d = pick ? bus.divisor1_in : bus.divisor0_in;
                    state_d   = StLaunch;
                end
            end
            StLaunch: begin
                if (divisor_q == '0) begin
                    quot_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    state_d = StGuard;
                end
            end
            StGuard: begin
                // Divider busy may lag the start pulse by a cycle; do not sample it here.
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (!bus.div_busy_in) begin
                    quot_d  = neg_q ? ('0 - bus.div_quotient_in) : bus.div_quotient_in;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    quot_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign winner_onehot = winner_q ? 2'b10 : 2'b01;

    always_comb begin
        bus.ack_out          = 2'b00;
        bus.result_valid_out = 2'b00;
        if (state_q == StLaunch) begin
            bus.ack_out = winner_onehot;
        end
        if (state_q == StResp) begin
            bus.result_valid_out = winner_onehot;
        end
    end

    assign bus.busy_out         = (state_q != StIdle);
    assign bus.div_start_out    = (state_q == StLaunch) && (divisor_q != '0);
    assign bus.div_dividend_out = mag_q;
    assign bus.div_divisor_out  = WIDTH'(divisor_q);
    assign bus.quotient_out     = quot_q;
    assign bus.err_out          = err_q;
endmodule
